// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the fetch (imem)
// and load/store (dmem) ports, with alignment/range checking and load extension.
module mem_port_arbiter #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_req_valid,
    output logic              imem_req_ready,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rsp_valid,
    output logic [31:0]       imem_rsp_data,
    output logic              imem_rsp_err,
    input  logic              dmem_req_valid,
    output logic              dmem_req_ready,
    input  logic              dmem_we,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [31:0]       dmem_wdata,
    input  logic [1:0]        dmem_size,
    input  logic              dmem_unsigned,
    output logic              dmem_rsp_valid,
    output logic [31:0]       dmem_rsp_data,
    output logic              dmem_rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    output logic [3:0]        mem_byte_enable,
    input  logic [31:0]       mem_read_data
);

    localparam int EW = ADDR_W + 1;

    typedef enum logic {IDLE, ACCESS} state_t;
    typedef enum logic {PORT_IMEM, PORT_DMEM} port_t;

    state_t            state, state_next;
    port_t             last_grant, req_port;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_size;
    logic              req_we, req_unsigned, req_err;

    logic              accept, pick_dmem, sel_err;
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        sel_size;
    logic [2:0]        sel_bytes;
    logic [EW-1:0]     sel_end;
    logic [31:0]       load_data;

    // dmem wins a tie unless it was the last port served
    assign pick_dmem = dmem_req_valid && (!imem_req_valid || last_grant == PORT_IMEM);
    assign accept    = (state == IDLE) && (imem_req_valid || dmem_req_valid);
    assign sel_addr  = pick_dmem ? dmem_addr : imem_addr;
    assign sel_size  = pick_dmem ? dmem_size : 2'b10;

    assign imem_req_ready = (state == IDLE);
    assign dmem_req_ready = (state == IDLE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel_bytes = 3'd4;
        sel_err   = 1'b0;
        case (sel_size)
            2'b00:   sel_bytes = 3'd1;
            2'b01:   begin sel_bytes = 3'd2; sel_err = sel_addr[0];    end
            2'b10:   begin sel_bytes = 3'd4; sel_err = |sel_addr[1:0]; end
            default: sel_err = 1'b1;
        endcase
        // one extra bit so an address near the top of the space cannot wrap past the check
        sel_end = {1'b0, sel_addr} + EW'(sel_bytes);
        if (sel_end > EW'(MEM_BYTES)) sel_err = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next      = state;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_addr        = '0;
        mem_write_data  = '0;
        mem_byte_enable = 4'b0000;
        case (state)
            IDLE: if (accept) state_next = ACCESS;
            ACCESS: begin
                state_next = IDLE;
                // rst gates the strobes so an abandoned store never reaches the memory
                if (!req_err && !rst) begin
                    mem_read       = ~req_we;
                    mem_write      = req_we;
                    mem_addr       = req_addr;
                    mem_write_data = req_wdata;
                    case (req_size)
                        2'b00:   mem_byte_enable = 4'b0001;
                        2'b01:   mem_byte_enable = 4'b0011;
                        default: mem_byte_enable = 4'b1111;
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= PORT_IMEM;
            req_port     <= PORT_IMEM;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_size     <= 2'b00;
            req_we       <= 1'b0;
            req_unsigned <= 1'b0;
            req_err      <= 1'b0;
        end else if (accept) begin
            last_grant   <= pick_dmem ? PORT_DMEM : PORT_IMEM;
            req_port     <= pick_dmem ? PORT_DMEM : PORT_IMEM;
            req_addr     <= sel_addr;
            req_wdata    <= pick_dmem ? dmem_wdata : 32'h0;
            req_size     <= sel_size;
            req_we       <= pick_dmem & dmem_we;
            req_unsigned <= pick_dmem & dmem_unsigned;
            req_err      <= sel_err;
        end
    end

    always_comb begin
        load_data = 32'h0;
        if (!req_we && !req_err) begin
            case (req_size)
                2'b00:   load_data = req_unsigned ? {24'h0, mem_read_data[7:0]}
                                                  : {{24{mem_read_data[7]}}, mem_read_data[7:0]};
                2'b01:   load_data = req_unsigned ? {16'h0, mem_read_data[15:0]}
                                                  : {{16{mem_read_data[15]}}, mem_read_data[15:0]};
                default: load_data = mem_read_data;
            endcase
        end
    end

    // response outputs are single-cycle pulses, zero whenever valid is low
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
            imem_rsp_err   <= 1'b0;
            dmem_rsp_valid <= 1'b0;
            dmem_rsp_data  <= 32'h0;
            dmem_rsp_err   <= 1'b0;
        end else begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
            imem_rsp_err   <= 1'b0;
            dmem_rsp_valid <= 1'b0;
            dmem_rsp_data  <= 32'h0;
            dmem_rsp_err   <= 1'b0;
            if (state == ACCESS) begin
                if (req_port == PORT_DMEM) begin
                    dmem_rsp_valid <= 1'b1;
                    dmem_rsp_data  <= load_data;
                    dmem_rsp_err   <= req_err;
                end else begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= load_data;
                    imem_rsp_err   <= req_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a byte-array memory model plus hand-computed
// expectations for fetches, loads, stores, arbitration, errors and mid-access reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid, imem_rsp_err;
    logic [31:0] imem_addr, imem_rsp_data;
    logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_unsigned;
    logic        dmem_rsp_valid, dmem_rsp_err;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rsp_data;
    logic [1:0]  dmem_size;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic [3:0]  mem_byte_enable;

    logic [7:0]  mem [0:1023];
    int          n_checks = 0;
    int          n_fail   = 0;

    mem_port_arbiter #(.MEM_BYTES(1024), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_size(dmem_size), .dmem_unsigned(dmem_unsigned),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data),
        .dmem_rsp_err(dmem_rsp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_byte_enable(mem_byte_enable),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // memory model: combinational read from mem_addr, lane-masked write on the clock edge
    always_comb begin
        mem_read_data = 32'h0;
        for (int i = 0; i < 4; i++)
            if (mem_addr + 32'(i) < 32'd1024)
                mem_read_data[8*i +: 8] = mem[mem_addr[9:0] + 10'(i)];
    end

    always @(posedge clk) begin
        if (mem_write)
            for (int i = 0; i < 4; i++)
                if (mem_byte_enable[i] && (mem_addr + 32'(i) < 32'd1024))
                    mem[mem_addr[9:0] + 10'(i)] <= mem_write_data[8*i +: 8];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    // one isolated request: handshake in N, memory strobes in N+1, response in N+2
    task automatic access(input string tag, input logic is_dmem, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns,
                          input logic [31:0] exp_data, input logic exp_err,
                          input logic [3:0] exp_be);
        if (is_dmem) begin
            dmem_req_valid = 1'b1; dmem_we = we; dmem_addr = addr;
            dmem_wdata = wdata; dmem_size = size; dmem_unsigned = uns;
        end else begin
            imem_req_valid = 1'b1; imem_addr = addr;
        end
        check({tag, " ready"}, {31'h0, is_dmem ? dmem_req_ready : imem_req_ready}, 32'h1);
        step();
        imem_req_valid = 1'b0;
        dmem_req_valid = 1'b0;
        check({tag, " mem_read"},  {31'h0, mem_read},  {31'h0, !exp_err && !we});
        check({tag, " mem_write"}, {31'h0, mem_write}, {31'h0, !exp_err && we});
        check({tag, " byte_en"},   {28'h0, mem_byte_enable}, {28'h0, exp_be});
        if (!exp_err) check({tag, " mem_addr"}, mem_addr, addr);
        check({tag, " early_rsp"}, {30'h0, imem_rsp_valid, dmem_rsp_valid}, 32'h0);
        step();
        if (is_dmem) begin
            check({tag, " rsp_valid"}, {30'h0, imem_rsp_valid, dmem_rsp_valid}, 32'h1);
            check({tag, " rsp_data"},  dmem_rsp_data, exp_data);
            check({tag, " rsp_err"},   {31'h0, dmem_rsp_err}, {31'h0, exp_err});
        end else begin
            check({tag, " rsp_valid"}, {30'h0, imem_rsp_valid, dmem_rsp_valid}, 32'h2);
            check({tag, " rsp_data"},  imem_rsp_data, exp_data);
            check({tag, " rsp_err"},   {31'h0, imem_rsp_err}, {31'h0, exp_err});
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        {mem[3], mem[2], mem[1], mem[0]}                 = 32'h12345678;
        {mem[19], mem[18], mem[17], mem[16]}             = 32'h11223344;
        {mem[35], mem[34], mem[33], mem[32]}             = 32'hC3017F80;
        {mem[39], mem[38], mem[37], mem[36]}             = 32'hDDCCBBAA;
        {mem[1023], mem[1022], mem[1021], mem[1020]}     = 32'h04030201;

        rst = 1'b1;
        imem_req_valid = 1'b0; imem_addr = 32'h0;
        dmem_req_valid = 1'b0; dmem_we = 1'b0; dmem_addr = 32'h0;
        dmem_wdata = 32'h0; dmem_size = 2'b00; dmem_unsigned = 1'b0;
        step();
        step();
        rst = 1'b0;

        // reset state
        check("rst ready",   {30'h0, imem_req_ready, dmem_req_ready}, 32'h3);
        check("rst rsp",     {28'h0, imem_rsp_valid, imem_rsp_err, dmem_rsp_valid, dmem_rsp_err}, 32'h0);
        check("rst rspdata", imem_rsp_data | dmem_rsp_data, 32'h0);
        check("rst memctl",  {26'h0, mem_read, mem_write, mem_byte_enable}, 32'h0);
        check("rst memaddr", mem_addr | mem_write_data, 32'h0);

        access("fetch10", 1'b0, 1'b0, 32'h010, 32'h0, 2'b10, 1'b0, 32'h11223344, 1'b0, 4'hF);

        // tie after reset: dmem first, then a second tie goes to imem
        imem_req_valid = 1'b1; imem_addr = 32'h000;
        dmem_req_valid = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h020; dmem_size = 2'b10;
        dmem_unsigned = 1'b0;
        step();
        check("tie1 addr",  mem_addr, 32'h020);
        check("tie1 ready", {31'h0, dmem_req_ready}, 32'h0);
        dmem_req_valid = 1'b0;
        step();
        check("tie1 rsp",   {30'h0, imem_rsp_valid, dmem_rsp_valid}, 32'h1);
        check("tie1 data",  dmem_rsp_data, 32'hC3017F80);
        check("tie1 rdy2",  {31'h0, imem_req_ready}, 32'h1);
        dmem_req_valid = 1'b1; dmem_addr = 32'h024;
        step();
        check("tie2 addr",  mem_addr, 32'h000);
        imem_req_valid = 1'b0;
        step();
        check("tie2 rsp",   {30'h0, imem_rsp_valid, dmem_rsp_valid}, 32'h2);
        check("tie2 data",  imem_rsp_data, 32'h12345678);
        step();
        check("tie3 addr",  mem_addr, 32'h024);
        dmem_req_valid = 1'b0;
        step();
        check("tie3 rsp",   {30'h0, imem_rsp_valid, dmem_rsp_valid}, 32'h1);
        check("tie3 data",  dmem_rsp_data, 32'hDDCCBBAA);

        // stores and extended loads
        access("sw40",  1'b1, 1'b1, 32'h040, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0, 4'hF);
        check("sw40 mem", mem_word(32'h40), 32'hDEADBEEF);
        access("lb40",  1'b1, 1'b0, 32'h040, 32'h0, 2'b00, 1'b0, 32'hFFFFFFEF, 1'b0, 4'h1);
        access("lbu40", 1'b1, 1'b0, 32'h040, 32'h0, 2'b00, 1'b1, 32'h000000EF, 1'b0, 4'h1);
        access("lh42",  1'b1, 1'b0, 32'h042, 32'h0, 2'b01, 1'b0, 32'hFFFFDEAD, 1'b0, 4'h3);
        access("lhu20", 1'b1, 1'b0, 32'h020, 32'h0, 2'b01, 1'b1, 32'h00007F80, 1'b0, 4'h3);
        access("lb20",  1'b1, 1'b0, 32'h020, 32'h0, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0, 4'h1);
        access("sb43",  1'b1, 1'b1, 32'h043, 32'h0000005A, 2'b00, 1'b0, 32'h0, 1'b0, 4'h1);
        access("lw40",  1'b1, 1'b0, 32'h040, 32'h0, 2'b10, 1'b0, 32'h5AADBEEF, 1'b0, 4'hF);

        // legality and range
        access("lh41",  1'b1, 1'b0, 32'h041, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 4'h0);
        access("lw3FE", 1'b1, 1'b0, 32'h3FE, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 4'h0);
        access("size3", 1'b1, 1'b0, 32'h050, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 4'h0);
        access("lw3FC", 1'b1, 1'b0, 32'h3FC, 32'h0, 2'b10, 1'b0, 32'h04030201, 1'b0, 4'hF);
        access("lb3FF", 1'b1, 1'b0, 32'h3FF, 32'h0, 2'b00, 1'b0, 32'h00000004, 1'b0, 4'h1);
        access("lw400", 1'b1, 1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 4'h0);
        access("sw400", 1'b1, 1'b1, 32'h400, 32'h12345678, 2'b10, 1'b0, 32'h0, 1'b1, 4'h0);
        access("wrap",  1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 4'h0);
        access("fetch12", 1'b0, 1'b0, 32'h012, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 4'h0);
        check("sw400 mem", mem_word(32'h3FC), 32'h04030201);

        // reset during a store's access cycle
        dmem_req_valid = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h060;
        dmem_wdata = 32'hCAFEF00D; dmem_size = 2'b10; dmem_unsigned = 1'b0;
        step();
        dmem_req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid write", {31'h0, mem_write}, 32'h0);
        step();
        rst = 1'b0;
        check("rstmid rsp",   {30'h0, imem_rsp_valid, dmem_rsp_valid}, 32'h0);
        check("rstmid ready", {30'h0, imem_req_ready, dmem_req_ready}, 32'h3);
        step();
        check("rstmid rsp2",  {30'h0, imem_rsp_valid, dmem_rsp_valid}, 32'h0);
        check("rstmid rdy2",  {31'h0, dmem_req_ready}, 32'h1);
        check("rstmid mem",   mem_word(32'h60), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 1 KB byte-addressed data memory between the instruction-fetch port (imem) and the load/store port (dmem).
- Accepts requests on valid/ready handshakes and arbitrates round-robin.
- Drives the memory's mem_read/mem_write/addr/write_data/byte_enable, checks alignment and range, and returns registered, sign/zero-extended responses.
- Sits between the core pipeline and the memory instance.

Parameters:
- MEM_BYTES, 1024, memory size in bytes; an access whose last byte is at or beyond MEM_BYTES is an error.
- ADDR_W, 32, request address width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- imem_req_valid  input  1  fetch request
- imem_req_ready  output  1  arbiter can accept a request
- imem_addr  input  32  fetch byte address (always a word access)
- imem_rsp_valid  output  1  one-cycle response pulse
- imem_rsp_data  output  32  fetched word
- imem_rsp_err  output  1  misaligned or out-of-range fetch
- dmem_req_valid  input  1  load/store request
- dmem_req_ready  output  1  arbiter can accept a request
- dmem_we  input  1  1 = store, 0 = load
- dmem_addr  input  32  byte address
- dmem_wdata  input  32  store data, right-justified
- dmem_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- dmem_unsigned  input  1  zero-extend load when 1
- dmem_rsp_valid  output  1  one-cycle response pulse
- dmem_rsp_data  output  32  extended load data (0 for stores)
- dmem_rsp_err  output  1  misaligned, illegal size or out of range
- mem_read  output  1  memory read enable
- mem_write  output  1  memory write enable
- mem_addr  output  32  memory byte address
- mem_write_data  output  32  memory write data
- mem_byte_enable  output  4  memory byte lanes
- mem_read_data  input  32  memory combinational read data

Behaviour:
- Reset:
  - Synchronous, active-high; clk is the only clock.
  - On reset: state=IDLE; all rsp_valid/rsp_err/rsp_data = 0; mem_read=mem_write=0; mem_addr/mem_write_data/mem_byte_enable = 0; last_grant=IMEM.
- FSM states: IDLE, ACCESS.
  - imem_req_ready = dmem_req_ready = (state==IDLE). Both readies are asserted together.
  - IDLE: if any valid, grant one, register its request fields, go to ACCESS. Otherwise stay.
  - ACCESS: drive memory for exactly one cycle, capture the result, return to IDLE.
- Arbitration:
  - Single requester is granted immediately.
  - Both valid: grant the port that is not last_grant; update last_grant to the winner. After reset, dmem wins the first tie.
  - The losing requester must hold valid; it is granted the next time IDLE is entered.
- Latency:
  - Handshake in cycle N → ACCESS in N+1 → rsp_valid high for exactly one cycle in N+2.
  - A new request may be accepted in N+2 (rsp_valid and ready coincide).
  - Throughput: one access per 2 cycles.
- Legality (computed at accept, registered):
  - Size-to-bytes mapping: byte=1, half=2, word=4.
  - Illegal if size==11, or half with addr[0]!=0, or word with addr[1:0]!=0, or addr+bytes > MEM_BYTES. Compute addr+bytes at 33 bits so wrap-around cannot pass the check.
  - imem requests are always word size.
- ACCESS, legal request:
  - mem_addr = registered address.
  - mem_byte_enable = 0001 / 0011 / 1111 for byte / half / word. Lanes are not shifted: the memory indexes bytes from addr.
  - mem_write_data = registered wdata, unshifted.
  - mem_read = ~we; mem_write = we.
- ACCESS, illegal request: mem_read = mem_write = 0, byte_enable = 0, no memory side effect. The response carries err=1 and data=0.
- Memory outputs are 0 in IDLE.
- Load extension, applied to mem_read_data captured at the end of ACCESS:
  - Byte: bits[7:0], sign-extended from bit 7 unless dmem_unsigned.
  - Half: bits[15:0], extended from bit 15 unless dmem_unsigned.
  - Word: passed through.
- Store response: rsp_valid=1, data=0, err=0.
- Response routing: only the granted port's rsp_valid pulses. The other port's rsp outputs stay 0.
- Reset mid-operation: a pending ACCESS is abandoned. No memory write occurs if rst is high in that cycle, no response is issued, and state returns to IDLE.
- rsp_data and rsp_err are 0 whenever the corresponding rsp_valid is 0.

Test Plan:
- Reset, then imem fetch at 0x010 with mem[0x010..0x013]=44,33,22,11 → imem_rsp_valid in cycle N+2, data 0x11223344, err 0; mem_read high only in N+1.
- Simultaneous imem@0x000 and dmem load@0x020 after reset → dmem granted first, imem next; responses at N+2 and N+4; a second tie goes to imem.
- dmem store word 0xDEADBEEF @0x040, then byte load signed/unsigned @0x040 → 0xFFFFFFEF / 0x000000EF; half load signed @0x042 → 0xFFFFDEAD.
- dmem store byte 0x5A @0x043 → byte_enable 0001, addr 0x043; word read @0x040 returns 0x5AADBEEF.
- Errors: half @0x041, word @0x3FE, size 11, and word @0x3FC (legal; last byte 0x3FF) versus word @0x400 (error) → err=1, data 0, mem_write/mem_read never asserted for the illegal requests.
- Store issued, rst asserted during its ACCESS cycle → memory unchanged, no rsp_valid, ready=1 the cycle after reset is released.
